// File: rtl/lfsr_step_ctrl_if.sv
// Control/status bundle between a sequencer master and the lfsr_step_ctrl slave.
// The slave receives rate/mode/trigger and returns step, dir, busy and done.
interface lfsr_step_ctrl_if #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
) ();
  logic                enable;
  logic [1:0]          mode;
  logic [PERIOD_W-1:0] period;
  logic [COUNT_W-1:0]  count;
  logic                trigger;
  logic                step;
  logic                dir;
  logic                busy;
  logic                done;

  modport master (
    output enable, mode, period, count, trigger,
    input  step, dir, busy, done
  );

  modport slave (
    input  enable, mode, period, count, trigger,
    output step, dir, busy, done
  );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// Step/direction sequencer for the lfsr noise register: clock divider plus
// free-run, burst and ping-pong (N forward then N reverse) sequencing.
module lfsr_step_ctrl #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  lfsr_step_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FREE, FWD, REV, FIN} state_t;

  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b11;

  state_t              state;
  logic [PERIOD_W-1:0] div_cnt;
  logic [PERIOD_W-1:0] period_l;
  logic [COUNT_W-1:0]  remaining;
  logic [COUNT_W-1:0]  count_l;
  logic [1:0]          mode_l;
  logic                step_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      period_l  <= '0;
      remaining <= '0;
      count_l   <= '0;
      mode_l    <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (bus.mode == MODE_FREE) begin
              state   <= FREE;
              div_cnt <= bus.period;
              busy_q  <= 1'b1;
            end else if (bus.mode[1] && bus.trigger) begin
              period_l  <= bus.period;
              count_l   <= bus.count;
              mode_l    <= bus.mode;
              remaining <= bus.count;
              div_cnt   <= bus.period;
              busy_q    <= 1'b1;
              state     <= (bus.count == '0) ? FIN : FWD;
            end
          end
        end

        FREE: begin
          if (bus.mode != MODE_FREE) begin
            state   <= IDLE;
            div_cnt <= '0;
            busy_q  <= 1'b0;
          end else if (bus.enable) begin
            if (div_cnt == '0) begin
              step_q  <= 1'b1;
              div_cnt <= bus.period;
            end else begin
              div_cnt <= div_cnt - PERIOD_W'(1);
            end
          end
        end

        FWD, REV: begin
          if (bus.enable) begin
            // dir rises on a quiet edge of its own so the lfsr never sees it
            // change together with a step, even at period 0.
            if (state == REV && !dir_q) begin
              dir_q <= 1'b1;
            end else if (div_cnt != '0) begin
              div_cnt <= div_cnt - PERIOD_W'(1);
            end else begin
              step_q    <= 1'b1;
              div_cnt   <= period_l;
              remaining <= remaining - COUNT_W'(1);
              if (remaining == COUNT_W'(1)) begin
                if (state == FWD && mode_l == MODE_PING) begin
                  state     <= REV;
                  remaining <= count_l;
                end else begin
                  state <= FIN;
                end
              end
            end
          end
        end

        FIN: begin
          if (bus.enable) begin
            done_q <= 1'b1;
            dir_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          dir_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Scoreboard bench for lfsr_step_ctrl: stimulus queues expected step/done
// events with their edge numbers, a negedge monitor pops and compares them.
module tb_lfsr_step_ctrl;

  typedef struct {
    logic is_done;
    int   cyc;
    logic dir;
    logic chk_lfsr;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   t0;
  logic [7:0] lfsr;
  logic dir_prev;
  exp_t exp_q[$];

  lfsr_step_ctrl_if bus ();

  lfsr_step_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference 8-bit Fibonacci lfsr (taps 8'hB8) stepped by the DUT.
  always @(posedge clk) begin
    if (!reset)
      lfsr <= 8'hFF;
    else if (bus.step)
      lfsr <= bus.dir ? {lfsr[0] ^ lfsr[6] ^ lfsr[5] ^ lfsr[4], lfsr[7:1]}
                      : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic push(input logic is_done, input int c, input logic d, input logic chk);
    exp_t e;
    e.is_done  = is_done;
    e.cyc      = c;
    e.dir      = d;
    e.chk_lfsr = chk;
    exp_q.push_back(e);
  endtask

  // Return 1 ns after posedge number e (immediately if already past it).
  task automatic at_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.step || bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus.step, bus.done}, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", bus.done, e.is_done);
        check("event_cycle", cyc, e.cyc);
        check("event_dir", bus.dir, e.dir);
        if (bus.step) check("dir_stable_at_step", bus.dir, dir_prev);
        if (e.chk_lfsr) check("lfsr_final", lfsr, 8'hFF);
      end
    end
    dir_prev <= bus.dir;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b0;
    bus.enable  = 1'b0;
    bus.mode    = 2'b00;
    bus.period  = '0;
    bus.count   = '0;
    bus.trigger = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_step", bus.step, 0);
    check("rst_dir",  bus.dir,  0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.enable = 1'b1;

    // Ping-pong, period 2, count 7: lfsr must return to 8'hFF.
    bus.period  = 16'd2;
    bus.count   = 8'd7;
    bus.mode    = 2'b11;
    bus.trigger = 1'b1;
    t0 = cyc + 1;
    for (int k = 1; k <= 7; k++) push(1'b0, t0 + 3 * k, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) push(1'b0, t0 + 22 + 3 * k, 1'b1, 1'b0);
    push(1'b1, t0 + 44, 1'b0, 1'b1);
    at_edge(t0);
    bus.trigger = 1'b0;
    at_edge(t0 + 23);
    @(negedge clk);
    check("pp_dir_lead_a", bus.dir, 1);
    check("pp_busy", bus.busy, 1);
    at_edge(t0 + 24);
    @(negedge clk);
    check("pp_dir_lead_b", bus.dir, 1);
    drain("pp_drain", 100);

    // Free-run, period 3; leaving mode 01 just before a step edge.
    bus.period = 16'd3;
    bus.mode   = 2'b01;
    t0 = cyc + 1;
    for (int k = 1; k <= 3; k++) push(1'b0, t0 + 4 * k, 1'b0, 1'b0);
    at_edge(t0 + 15);
    bus.mode = 2'b00;
    at_edge(t0 + 16);
    @(negedge clk);
    check("free_exit_busy", bus.busy, 0);
    check("free_exit_step", bus.step, 0);
    repeat (10) @(negedge clk);
    drain("free_drain", 5);

    // Burst, period 0, count 5, with an ignored trigger mid-burst.
    bus.period  = 16'd0;
    bus.count   = 8'd5;
    bus.mode    = 2'b10;
    bus.trigger = 1'b1;
    t0 = cyc + 1;
    for (int k = 1; k <= 5; k++) push(1'b0, t0 + k, 1'b0, 1'b0);
    push(1'b1, t0 + 6, 1'b0, 1'b0);
    at_edge(t0);
    bus.trigger = 1'b0;
    at_edge(t0 + 2);
    bus.trigger = 1'b1;
    at_edge(t0 + 3);
    bus.trigger = 1'b0;
    drain("burst_drain", 20);
    repeat (5) @(negedge clk);

    // Burst with count 0: busy for one cycle, then done.
    bus.count   = 8'd0;
    bus.trigger = 1'b1;
    t0 = cyc + 1;
    push(1'b1, t0 + 1, 1'b0, 1'b0);
    at_edge(t0);
    bus.trigger = 1'b0;
    @(negedge clk);
    check("zero_busy_on", bus.busy, 1);
    check("zero_no_step", bus.step, 0);
    at_edge(t0 + 1);
    @(negedge clk);
    check("zero_busy_off", bus.busy, 0);
    drain("zero_drain", 5);

    // Burst count 4, period 1, paused for 10 edges after step 2.
    bus.period  = 16'd1;
    bus.count   = 8'd4;
    bus.trigger = 1'b1;
    t0 = cyc + 1;
    push(1'b0, t0 + 2,  1'b0, 1'b0);
    push(1'b0, t0 + 4,  1'b0, 1'b0);
    push(1'b0, t0 + 16, 1'b0, 1'b0);
    push(1'b0, t0 + 18, 1'b0, 1'b0);
    push(1'b1, t0 + 19, 1'b0, 1'b0);
    at_edge(t0);
    bus.trigger = 1'b0;
    at_edge(t0 + 4);
    bus.enable = 1'b0;
    at_edge(t0 + 9);
    @(negedge clk);
    check("pause_busy", bus.busy, 1);
    at_edge(t0 + 14);
    bus.enable = 1'b1;
    drain("pause_drain", 30);

    // Reset during the reverse half of a ping-pong.
    bus.period  = 16'd0;
    bus.count   = 8'd3;
    bus.mode    = 2'b11;
    bus.trigger = 1'b1;
    t0 = cyc + 1;
    push(1'b0, t0 + 1, 1'b0, 1'b0);
    push(1'b0, t0 + 2, 1'b0, 1'b0);
    push(1'b0, t0 + 3, 1'b0, 1'b0);
    push(1'b0, t0 + 5, 1'b1, 1'b0);
    at_edge(t0);
    bus.trigger = 1'b0;
    at_edge(t0 + 5);
    reset = 1'b0;
    at_edge(t0 + 6);
    @(negedge clk);
    check("midrst_step", bus.step, 0);
    check("midrst_dir",  bus.dir,  0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    at_edge(t0 + 7);
    reset    = 1'b1;
    bus.mode = 2'b00;
    repeat (8) @(negedge clk);
    drain("final_drain", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
